// File: rtl/ledr_sched_pkg.sv
// Shared types and constants for the LED pattern scheduler.
package ledr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_PEND  = 2'd2
  } state_e;

  localparam logic [3:0] CFG_SEL_PERIOD = 4'd8;
  localparam logic [3:0] CFG_SEL_CTRL   = 4'd9;

  localparam logic [2:0] DM_BYTE = 3'd0;
  localparam logic [2:0] DM_HALF = 3'd1;
  localparam logic [2:0] DM_WORD = 3'd2;

  localparam int unsigned CTRL_RUN     = 0;
  localparam int unsigned CTRL_LEN_LSB = 1;
  localparam int unsigned CTRL_LEN_MSB = 3;
  localparam int unsigned CTRL_ONESHOT = 4;

  // Builds a control-register word from its fields.
  function automatic logic [31:0] ctrl_word(input logic run, input logic [2:0] len_m1,
                                            input logic oneshot);
    logic [31:0] w;
    w = '0;
    w[CTRL_RUN] = run;
    w[CTRL_LEN_MSB:CTRL_LEN_LSB] = len_m1;
    w[CTRL_ONESHOT] = oneshot;
    return w;
  endfunction

  function automatic int unsigned dm_bytes(input logic [2:0] dm);
    case (dm)
      DM_BYTE: return 1;
      DM_HALF: return 2;
      DM_WORD: return 4;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/ledr_sched_tick_cnt.sv
// Tick counter for the scheduler: clear, enable and terminal-count compare.
module ledr_tick_cnt #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                tc_o
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] last;

  // A period of 0 behaves as 1; >= keeps a shrunk period from overrunning.
  assign last = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
  assign tc_o = (cnt_q >= last);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/ledr_sched.sv
// LED pattern scheduler: plays a pattern table into the LED store, yielding to CPU stores.
// Optional one-shot playback is enabled by defining LEDR_SCHED_ONESHOT_EN.
module ledr_sched
  import ledr_sched_pkg::*;
#(
  parameter int PERIOD_W = 24,
  parameter int DEPTH    = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_st_en_i,
  input  logic [2:0]  cpu_datamode_i,
  input  logic [3:0]  cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_sel_i,
  input  logic [31:0] cfg_data_i,
  output logic        led_st_en_o,
  output logic [2:0]  led_datamode_o,
  output logic [3:0]  led_addr_o,
  output logic [31:0] led_data_o,
  output logic        busy_o,
  output logic [2:0]  pat_idx_o,
  output logic        done_o
);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] period_q;
  logic [2:0]          len_m1_q;
  logic [2:0]          idx_q;
  logic [2:0]          idx_next;
  logic [31:0]         pattern_q [DEPTH];
  logic                ctrl_wr, issue, tc, cnt_clr, cnt_en, oneshot, finish;

  assign ctrl_wr = cfg_we_i && (cfg_sel_i == CFG_SEL_CTRL);
  // Any control write cancels a pending engine write in the same cycle.
  assign issue   = (state_q == ST_PEND) && !cpu_st_en_i && !ctrl_wr && !rst_i;
  assign idx_next = (idx_q >= len_m1_q) ? 3'd0 : idx_q + 3'd1;
  assign finish  = issue && oneshot && (idx_q == len_m1_q);
  assign cnt_clr = ctrl_wr || issue;
  assign cnt_en  = (state_q == ST_COUNT) && !tc;

  ledr_tick_cnt #(.PERIOD_W(PERIOD_W)) u_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .period_i (period_q),
    .tc_o     (tc)
  );

`ifdef LEDR_SCHED_ONESHOT_EN
  logic oneshot_q;
  logic done_q;

  assign oneshot = oneshot_q;
  assign done_o  = done_q && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oneshot_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= finish;
      if (ctrl_wr) begin
        oneshot_q <= cfg_data_i[CTRL_ONESHOT];
      end
    end
  end
`else
  assign oneshot = 1'b0;
  assign done_o  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (ctrl_wr) begin
      state_d = cfg_data_i[CTRL_RUN] ? ST_COUNT : ST_IDLE;
    end else begin
      case (state_q)
        ST_COUNT: if (tc) state_d = ST_PEND;
        ST_PEND:  if (issue) state_d = finish ? ST_IDLE : ST_COUNT;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= 3'd0;
      len_m1_q <= 3'd0;
      period_q <= '0;
    end else begin
      state_q <= state_d;
      if (ctrl_wr) begin
        len_m1_q <= cfg_data_i[CTRL_LEN_MSB:CTRL_LEN_LSB];
        idx_q    <= 3'd0;
      end else if (issue) begin
        idx_q <= idx_next;
      end
      if (cfg_we_i && (cfg_sel_i == CFG_SEL_PERIOD)) begin
        period_q <= cfg_data_i[PERIOD_W-1:0];
      end
    end
  end

  // Table writes land after this cycle's read, so a same-cycle issue sees the old entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) pattern_q[i] <= '0;
    end else if (cfg_we_i && !cfg_sel_i[3]) begin
      pattern_q[cfg_sel_i[2:0]] <= cfg_data_i;
    end
  end

  always_comb begin
    led_st_en_o    = 1'b0;
    led_datamode_o = 3'd0;
    led_addr_o     = 4'd0;
    led_data_o     = 32'd0;
    if (cpu_st_en_i) begin
      led_st_en_o    = 1'b1;
      led_datamode_o = cpu_datamode_i;
      led_addr_o     = cpu_addr_i;
      led_data_o     = cpu_data_i;
    end else if (issue) begin
      led_st_en_o    = 1'b1;
      led_datamode_o = DM_WORD;
      led_data_o     = pattern_q[idx_q];
    end
  end

  assign busy_o    = (state_q != ST_IDLE) && !rst_i;
  assign pat_idx_o = idx_q;

endmodule

// File: tb/tb_ledr_sched.sv
// Randomized scoreboard bench for ledr_sched against a cycle-level behavioural model.
module tb_ledr_sched;
  import ledr_sched_pkg::*;

`ifdef LEDR_SCHED_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cpu_st_en_i = 1'b0;
  logic [2:0]  cpu_datamode_i = '0;
  logic [3:0]  cpu_addr_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic        cfg_we_i = 1'b0;
  logic [3:0]  cfg_sel_i = '0;
  logic [31:0] cfg_data_i = '0;
  logic        led_st_en_o;
  logic [2:0]  led_datamode_o;
  logic [3:0]  led_addr_o;
  logic [31:0] led_data_o;
  logic        busy_o;
  logic [2:0]  pat_idx_o;
  logic        done_o;

  ledr_sched #(.PERIOD_W(24), .DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_st_en_i(cpu_st_en_i), .cpu_datamode_i(cpu_datamode_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cfg_we_i(cfg_we_i), .cfg_sel_i(cfg_sel_i), .cfg_data_i(cfg_data_i),
    .led_st_en_o(led_st_en_o), .led_datamode_o(led_datamode_o),
    .led_addr_o(led_addr_o), .led_data_o(led_data_o),
    .busy_o(busy_o), .pat_idx_o(pat_idx_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    logic [2:0]  dm;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_on = 1'b0;
  bit   exp_busy, exp_done;
  logic [2:0] exp_idx;

  // Model: engine either stopped or waiting m_due cycles before wanting to write.
  bit          m_run, m_oneshot, m_done;
  int          m_due, m_idx, m_len, m_period;
  logic [31:0] m_pat [8];

  function automatic int peff();
    return (m_period == 0) ? 1 : m_period;
  endfunction

  task automatic step(input bit r, input bit ce, input logic [2:0] cdm, input logic [3:0] ca,
                      input logic [31:0] cdat, input bit we, input logic [3:0] sel,
                      input logic [31:0] wd);
    bit   cw, eng;
    exp_t e;
    rst_i = r; cpu_st_en_i = ce; cpu_datamode_i = cdm; cpu_addr_i = ca; cpu_data_i = cdat;
    cfg_we_i = we; cfg_sel_i = sel; cfg_data_i = wd;
    cw = we && (sel == 4'd9);
    exp_busy = m_run && !r;
    exp_done = m_done && !r;
    exp_idx  = 3'(m_idx);
    eng = m_run && (m_due == 0) && !ce && !cw && !r;
    e.cyc = cyc;
    if (ce) begin
      e.dm = cdm; e.addr = ca; e.data = cdat; expq.push_back(e);
    end else if (eng) begin
      e.dm = 3'd2; e.addr = 4'd0; e.data = m_pat[m_idx]; expq.push_back(e);
    end
    if (r) begin
      m_run = 0; m_due = 0; m_idx = 0; m_len = 1; m_period = 0; m_oneshot = 0; m_done = 0;
      for (int i = 0; i < 8; i++) m_pat[i] = '0;
    end else begin
      m_done = 0;
      if (cw) begin
        m_len = int'(wd[3:1]) + 1;
        m_oneshot = ONESHOT && wd[4];
        m_idx = 0;
        m_run = wd[0];
        m_due = peff();
      end else if (m_run) begin
        if (m_due > 0) m_due--;
        else if (eng) begin
          if (m_oneshot && m_idx == m_len - 1) begin m_run = 0; m_done = 1; end
          m_idx = (m_idx + 1 >= m_len) ? 0 : m_idx + 1;
          m_due = peff();
        end
      end
      if (we && sel == 4'd8) m_period = int'(wd[23:0]);
      if (we && sel < 4'd8) m_pat[sel[2:0]] = wd;
    end
    @(posedge clk_i); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 3'd0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
  endtask

  task automatic cfgw(input logic [3:0] s, input logic [31:0] d);
    step(0, 0, 3'd0, 4'd0, 32'd0, 1, s, d);
  endtask

  task automatic rst_cycle();
    step(1, 0, 3'd0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
  endtask

  always @(negedge clk_i) begin
    if (mon_on) begin
      checks++;
      if (busy_o !== exp_busy) begin
        errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, exp_busy);
      end
      checks++;
      if (pat_idx_o !== exp_idx) begin
        errors++; $display("FAIL pat_idx cyc=%0d got=%0d exp=%0d", cyc, pat_idx_o, exp_idx);
      end
      checks++;
      if (done_o !== exp_done) begin
        errors++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done_o, exp_done);
      end
      checks++;
      if (led_st_en_o === 1'b1) begin
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write cyc=%0d got data=%h exp none", cyc, led_data_o);
        end else begin
          exp_t e;
          e = expq.pop_front();
          if (e.cyc != cyc || led_datamode_o !== e.dm || led_addr_o !== e.addr ||
              led_data_o !== e.data) begin
            errors++;
            $display("FAIL led_write cyc=%0d got dm=%0d addr=%h data=%h exp cyc=%0d dm=%0d addr=%h data=%h",
                     cyc, led_datamode_o, led_addr_o, led_data_o, e.cyc, e.dm, e.addr, e.data);
          end
        end
      end else if (led_st_en_o !== 1'b0 || led_datamode_o !== 3'd0 || led_addr_o !== 4'd0 ||
                   led_data_o !== 32'd0) begin
        errors++;
        $display("FAIL led_idle cyc=%0d got en=%b dm=%0d addr=%h data=%h exp all zero",
                 cyc, led_st_en_o, led_datamode_o, led_addr_o, led_data_o);
      end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        errors++;
        $display("FAIL missed_write cyc=%0d got none exp data=%h", cyc, expq[0].data);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got timeout exp finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk_i); #1;
    rst_cycle();
    mon_on = 1'b1;
    rst_cycle();

    // Period 3, two entries, free running.
    cfgw(4'd0, 32'hA5A5_0001);
    cfgw(4'd1, 32'h5A5A_0002);
    cfgw(4'd8, 32'd3);
    cfgw(4'd9, ctrl_word(1'b1, 3'd1, 1'b0));
    idle(12);

    // CPU holds the store through the pending cycle and beyond.
    cfgw(4'd9, ctrl_word(1'b1, 3'd1, 1'b0));
    idle(3);
    for (int i = 0; i < 3; i++) step(0, 1, 3'd1, 4'(i + 3), 32'hC0DE_0000 + i, 0, 4'd0, 32'd0);
    idle(8);

    // Stop written in the pending cycle while the CPU stores.
    cfgw(4'd9, ctrl_word(1'b1, 3'd1, 1'b0));
    idle(3);
    step(0, 1, 3'd2, 4'h7, 32'hFEED_BEEF, 1, 4'd9, ctrl_word(1'b0, 3'd1, 1'b0));
    idle(5);

    // Same-cycle table write against an issue, then reset mid-count.
    cfgw(4'd9, ctrl_word(1'b1, 3'd1, 1'b0));
    idle(3);
    cfgw(4'd0, 32'h1111_2222);
    idle(2);
    rst_cycle();
    cfgw(4'd9, ctrl_word(1'b1, 3'd1, 1'b0));
    idle(8);

    // One-shot playback of three entries at period 1.
    cfgw(4'd0, 32'h0000_00A0);
    cfgw(4'd1, 32'h0000_00A1);
    cfgw(4'd2, 32'h0000_00A2);
    cfgw(4'd8, 32'd1);
    cfgw(4'd9, ctrl_word(1'b1, 3'd2, 1'b1));
    idle(10);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      bit          r, ce, we;
      logic [3:0]  sel;
      logic [31:0] wd;
      int          pick;
      r  = ($urandom_range(0, 399) == 0);
      ce = ($urandom_range(0, 3) == 0);
      we = ($urandom_range(0, 11) == 0);
      pick = $urandom_range(0, 99);
      wd = $urandom;
      if (pick < 55) sel = 4'($urandom_range(0, 7));
      else if (pick < 70) begin
        sel = 4'd9;
        wd  = ctrl_word($urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)), 1'($urandom));
      end else if (pick < 95 && !m_run) begin
        sel = 4'd8;
        wd  = 32'($urandom_range(0, 4));
      end else sel = 4'($urandom_range(10, 15));
      step(r, ce, 3'($urandom), 4'($urandom), $urandom, we, sel, wd);
    end
    idle(2);

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", expq.size());
    end
    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ledr_sched.md
LEDR_SCHED -- requirements
Module: ledr_sched

Interface
REQ-001 The block SHALL have parameters: PERIOD_W, default 24, tick-counter width; DEPTH, default 8, pattern-table entries (fixed power of two, 8).
REQ-002 Ports SHALL be: clk_i  in  1  sole clock, rising edge; rst_i  in  1  reset, synchronous, active-high.
REQ-003 Ports SHALL be: cpu_st_en_i in 1, cpu_datamode_i in 3, cpu_addr_i in 4, cpu_data_i in 32  CPU store request to LED store.
REQ-004 Ports SHALL be: cfg_we_i in 1, cfg_sel_i in 4 (0-7 pattern entry, 8 period, 9 control), cfg_data_i in 32  configuration write.
REQ-005 Ports SHALL be: led_st_en_o out 1, led_datamode_o out 3, led_addr_o out 4, led_data_o out 32  arbitrated store to LED store.
REQ-006 Ports SHALL be: busy_o out 1 (engine not IDLE), pat_idx_o out 3 (next entry index), done_o out 1 (one-shot completion pulse).

Function
REQ-007 The control register SHALL be: bit0 run, bits[3:1] len-1 (active entries = len), bit4 oneshot; the period register SHALL be PERIOD_W bits, with value 0 treated as 1.
REQ-008 The FSM SHALL have states IDLE, COUNT, PEND.
REQ-009 IDLE: when a control write sets run=1, the FSM SHALL clear idx and counter, then go to COUNT.
REQ-010 COUNT: the counter SHALL increment each cycle; at counter==period-1 the FSM SHALL go to PEND.
REQ-011 PEND with cpu_st_en_i=0: the block SHALL issue a word write (datamode 2, addr 0, data=pattern[idx]) that cycle, advance idx modulo len, clear the counter, and go to COUNT.
REQ-012 PEND with cpu_st_en_i=1: the CPU SHALL win, the engine write SHALL be deferred, and the FSM SHALL stay in PEND; the CPU is never stalled or dropped.
REQ-013 led_* outputs SHALL be combinational: CPU fields when cpu_st_en_i=1, engine write in PEND otherwise, else led_st_en_o=0 and the other outputs 0.
REQ-014 Uncontended interval between engine writes SHALL be period+1 cycles; the first write SHALL occur period+1 cycles after the run-setting cfg cycle.
REQ-015 A control write with run=0 SHALL force IDLE next cycle from any state; a pending engine write SHALL be discarded.
REQ-016 A pattern-entry write in the same cycle as its issue SHALL not affect that issue; the issue uses the old value.
REQ-017 If len is changed while running and idx >= new len, the next advance SHALL wrap idx to 0.
REQ-018 A control write with run=1 while already running SHALL restart the engine (idx=0, counter=0, COUNT).

Reset
REQ-019 On rst_i: state IDLE, counter 0, idx 0, period 0, control 0, pattern entries 0, done_o 0.
REQ-020 On rst_i, busy_o SHALL be 0 and led_* SHALL follow only the CPU inputs; reset mid-PEND SHALL drop the pending write.

Configuration
REQ-021 Macro LEDR_SCHED_ONESHOT_EN defined: with oneshot=1, issuing entry len-1 SHALL clear run, go to IDLE, and pulse done_o high for one cycle.
REQ-022 Macro LEDR_SCHED_ONESHOT_EN undefined: bit4 SHALL be ignored, playback SHALL loop forever, and done_o SHALL be tied 0.

Structure
REQ-023 Package ledr_sched_pkg SHALL hold the state enum, CFG_SEL_PERIOD=8, CFG_SEL_CTRL=9, DM_BYTE=0, DM_HALF=1, DM_WORD=2, and the control bit positions.
REQ-024 The tick counter SHALL be sub-module ledr_tick_cnt (clear, enable, terminal-count compare).

Verification
REQ-025 period=3, len=2, run=1 at cycle 0, no CPU -> engine writes at cycles 4, 8, 12 with data entry0, entry1, entry0.
REQ-026 cpu_st_en_i high in cycles 4-6 of the REQ-025 setup -> CPU fields pass through in cycles 4-6, engine write occurs at cycle 7, next engine write at cycle 11.
REQ-027 run=0 written in the PEND cycle while the CPU is storing -> no engine write ever issued, busy_o=0 next cycle.
REQ-028 With LEDR_SCHED_ONESHOT_EN, oneshot=1, len=3, period=1 -> three writes, each 2 cycles apart, done_o pulse in the cycle after the third write, then IDLE.
REQ-029 rst_i asserted mid-COUNT, then run=1 -> first write after period+1 cycles from entry 0 = 0 (pattern cleared); period=0 -> writes every 2 cycles.
